// File: rtl/temp_calc_seq_if.sv
// rtl/temp_calc_seq_if.sv - config, request and result bus of the sequential temperature calculator
// master drives config/requests and accepts results; slave is the calculator.
interface temp_calc_seq_if #(
   parameter int NUM_CH = 4,
   parameter int REF_W  = 8,
   parameter int ADC_W  = 16,
   parameter int BASE_W = 32
);
   localparam int CH_W = $clog2(NUM_CH);

   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [BASE_W-1:0] cfg_base;
   logic [REF_W-1:0]  cfg_ref;

   logic              in_valid;
   logic              in_ready;
   logic [CH_W-1:0]   in_ch;
   logic [ADC_W-1:0]  in_adc;

   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_ch;
   logic [BASE_W-1:0] out_temp;
   logic              out_ovf;

   modport master (
      output cfg_we, cfg_ch, cfg_base, cfg_ref,
      output in_valid, in_ch, in_adc,
      input  in_ready,
      output out_ready,
      input  out_valid, out_ch, out_temp, out_ovf
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_base, cfg_ref,
      input  in_valid, in_ch, in_adc,
      output in_ready,
      input  out_ready,
      output out_valid, out_ch, out_temp, out_ovf
   );
endinterface

// File: rtl/temp_calc_seq.sv
// rtl/temp_calc_seq.sv - multi-channel tempc = base +/- ((ref^2 * |adc|) >> SHIFT) on one shift-add multiplier
// Optional TEMP_CALC_SAT_EN: clamp out_temp on carry/borrow instead of wrapping.
module temp_calc_seq #(
   parameter int NUM_CH = 4,
   parameter int REF_W  = 8,
   parameter int ADC_W  = 16,
   parameter int BASE_W = 32,
   parameter int SHIFT  = 6
) (
   input  logic          clk,
   input  logic          rst,
   temp_calc_seq_if.slave bus
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int MAG_W = ADC_W - 1;
   localparam int SQ_W  = 2 * REF_W;
   localparam int P_W   = SQ_W + MAG_W;
   localparam int M_W   = (REF_W > MAG_W) ? REF_W : MAG_W;
   localparam int CNT_W = $clog2(M_W + 1);
   localparam int D_W   = (P_W > BASE_W) ? P_W : BASE_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ,
      S_MUL,
      S_ADD,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [BASE_W-1:0] cfg_base [NUM_CH];
   logic [REF_W-1:0]  cfg_ref  [NUM_CH];

   logic [CH_W-1:0]   job_ch;
   logic              job_sign;
   logic [MAG_W-1:0]  job_mag;
   logic [BASE_W-1:0] job_base;

   logic [P_W-1:0]    acc;
   logic [P_W-1:0]    mcand;
   logic [M_W-1:0]    mplier;
   logic [CNT_W-1:0]  cnt;

   logic [CH_W-1:0]   res_ch;
   logic [BASE_W-1:0] res_temp;
   logic              res_ovf;

   logic              accept;
   logic              last_step;
   logic [P_W-1:0]    acc_sum;

   logic [D_W-1:0]    d_wide;
   logic [BASE_W-1:0] d;
   logic [BASE_W:0]   sum;
   logic [BASE_W-1:0] temp_fin;

   assign accept    = (state == S_IDLE) && bus.in_valid;
   assign last_step = (cnt == '0);
   assign acc_sum   = acc + (mplier[0] ? mcand : '0);

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_ch    = res_ch;
   assign bus.out_temp  = res_temp;
   assign bus.out_ovf   = res_ovf;

   // Config file: writable in any state; jobs only ever read it at accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cfg_base[i] <= '0;
            cfg_ref[i]  <= '0;
         end
      end else if (bus.cfg_we) begin
         cfg_base[bus.cfg_ch] <= bus.cfg_base;
         cfg_ref[bus.cfg_ch]  <= bus.cfg_ref;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.in_valid)  state_nx = S_SQ;
         S_SQ:    if (last_step)     state_nx = S_MUL;
         S_MUL:   if (last_step)     state_nx = S_ADD;
         S_ADD:                      state_nx = S_DONE;
         S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
         default:                    state_nx = S_IDLE;
      endcase
   end

   // d is the scaled product fitted to BASE_W; bit BASE_W of sum is carry (add) or borrow (sub).
   always_comb begin
      d_wide   = D_W'(acc) >> SHIFT;
      d        = d_wide[BASE_W-1:0];
      sum      = job_sign ? ({1'b0, job_base} - {1'b0, d})
                          : ({1'b0, job_base} + {1'b0, d});
      temp_fin = sum[BASE_W-1:0];
`ifdef TEMP_CALC_SAT_EN
      if (sum[BASE_W]) begin
         temp_fin = job_sign ? '0 : '1;
      end
`endif
   end

   // Shared shift-add: SQ builds ref*ref in acc, which then becomes the multiplicand for MUL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         job_ch   <= '0;
         job_sign <= 1'b0;
         job_mag  <= '0;
         job_base <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         res_ch   <= '0;
         res_temp <= '0;
         res_ovf  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  job_ch   <= bus.in_ch;
                  job_sign <= bus.in_adc[ADC_W-1];
                  job_mag  <= bus.in_adc[MAG_W-1:0];
                  job_base <= cfg_base[bus.in_ch];
                  acc      <= '0;
                  mcand    <= P_W'(cfg_ref[bus.in_ch]);
                  mplier   <= M_W'(cfg_ref[bus.in_ch]);
                  cnt      <= CNT_W'(REF_W - 1);
               end
            end
            S_SQ: begin
               if (last_step) begin
                  acc    <= '0;
                  mcand  <= acc_sum;
                  mplier <= M_W'(job_mag);
                  cnt    <= CNT_W'(MAG_W - 1);
               end else begin
                  acc    <= acc_sum;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt - 1'b1;
               end
            end
            S_MUL: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
            end
            S_ADD: begin
               res_ch   <= job_ch;
               res_temp <= temp_fin;
               res_ovf  <= sum[BASE_W];
            end
            default: begin
            end
         endcase
      end
   end
endmodule
